// File: rtl/inst_fetch_responder_pkg.sv
// rtl/inst_fetch_responder_pkg.sv - shared widths, field offsets and FSM states for the fetch responder
package inst_fetch_responder_pkg;

  localparam int DEF_PC_BIT      = 8;
  localparam int DEF_INST_ID_BIT = 8;
  localparam int DEF_NUM_FU      = 8;
  localparam int DEF_NUM_REG     = 8;
  localparam int DEF_IMM_BIT     = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_LATENCY     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int op_bit_of(input int num_fu);
    return $clog2(num_fu);
  endfunction

  function automatic int reg_id_bit_of(input int num_reg);
    return $clog2(num_reg);
  endfunction

  // Word layout, MSB to LSB: op, dst, src0, src1, imm.
  function automatic int inst_w_of(input int op_bit, input int reg_id_bit, input int imm_bit);
    return op_bit + 3 * reg_id_bit + imm_bit;
  endfunction

  function automatic int src1_lsb_of(input int imm_bit);
    return imm_bit;
  endfunction

  function automatic int src0_lsb_of(input int imm_bit, input int reg_id_bit);
    return imm_bit + reg_id_bit;
  endfunction

  function automatic int dst_lsb_of(input int imm_bit, input int reg_id_bit);
    return imm_bit + 2 * reg_id_bit;
  endfunction

  function automatic int op_lsb_of(input int imm_bit, input int reg_id_bit);
    return imm_bit + 3 * reg_id_bit;
  endfunction

endpackage

// File: rtl/inst_fetch_responder_sync_fifo.sv
// rtl/inst_fetch_responder_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit full/empty detection
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Entry storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - program store, request FIFO and fixed-latency in-order fetch responder
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int  PC_BIT      = DEF_PC_BIT,
  parameter int  INST_ID_BIT = DEF_INST_ID_BIT,
  parameter int  NUM_FU      = DEF_NUM_FU,
  parameter int  NUM_REG     = DEF_NUM_REG,
  parameter int  IMM_BIT     = DEF_IMM_BIT,
  parameter int  FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int  LATENCY     = DEF_LATENCY,
  localparam int OP_BIT      = op_bit_of(NUM_FU),
  localparam int REG_ID_BIT  = reg_id_bit_of(NUM_REG),
  localparam int INST_W      = inst_w_of(OP_BIT, REG_ID_BIT, IMM_BIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_vld,
  output logic                   fetch_rdy,
  input  logic [INST_ID_BIT-1:0] fetch_id,
  input  logic [PC_BIT-1:0]      fetch_pc,
  output logic                   inst_vld,
  input  logic                   inst_rdy,
  output logic                   inst_last,
  output logic [OP_BIT-1:0]      inst_op,
  output logic [INST_ID_BIT-1:0] inst_id,
  output logic [REG_ID_BIT-1:0]  inst_dst_reg,
  output logic [REG_ID_BIT-1:0]  inst_src_reg0,
  output logic [REG_ID_BIT-1:0]  inst_src_reg1,
  output logic [IMM_BIT-1:0]     inst_imm,
  input  logic                   prog_wr_vld,
  output logic                   prog_wr_rdy,
  input  logic [PC_BIT-1:0]      prog_wr_addr,
  input  logic [INST_W-1:0]      prog_wr_data,
  input  logic                   prog_wr_last,
  output logic [PC_BIT-1:0]      drop_cnt,
  output logic                   busy
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LEN_W    = PC_BIT + 1;
  localparam int FIFO_W   = INST_ID_BIT + PC_BIT;
  localparam int OP_LSB   = op_lsb_of(IMM_BIT, REG_ID_BIT);
  localparam int DST_LSB  = dst_lsb_of(IMM_BIT, REG_ID_BIT);
  localparam int SRC0_LSB = src0_lsb_of(IMM_BIT, REG_ID_BIT);
  localparam int SRC1_LSB = src1_lsb_of(IMM_BIT);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [LEN_W-1:0]       prog_len;
  logic [INST_W-1:0]      store [2**PC_BIT];
  logic [INST_W-1:0]      word;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_W-1:0]      head;
  logic [INST_ID_BIT-1:0] head_id;
  logic [PC_BIT-1:0]      head_pc;
  logic                   head_hit;
  logic                   evaluate;
  logic                   prog_wr;

  assign head_id   = head[FIFO_W-1 -: INST_ID_BIT];
  assign head_pc   = head[PC_BIT-1:0];
  assign head_hit  = ({1'b0, head_pc} < prog_len);

  assign busy        = !fifo_empty || (state != ST_IDLE);
  assign fetch_rdy   = !fifo_full && !rst;
  assign prog_wr_rdy = !busy;
  assign prog_wr     = prog_wr_vld && prog_wr_rdy && !rst;
  assign fifo_push   = fetch_vld && fetch_rdy;

  // The head may be consumed when idle, or in the same cycle the core takes the current response.
  assign evaluate = (state == ST_IDLE) || ((state == ST_RESP) && inst_rdy);
  assign fifo_pop = evaluate && !fifo_empty;

  assign inst_op       = word[OP_LSB   +: OP_BIT];
  assign inst_dst_reg  = word[DST_LSB  +: REG_ID_BIT];
  assign inst_src_reg0 = word[SRC0_LSB +: REG_ID_BIT];
  assign inst_src_reg1 = word[SRC1_LSB +: REG_ID_BIT];
  assign inst_imm      = word[IMM_BIT-1:0];

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({fetch_id, fetch_pc}),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Program store: written only while nothing is in flight; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_wr) begin
      store[prog_wr_addr] <= prog_wr_data;
    end
  end

  // Read sequencer: pop, wait out the store latency, then hold the response until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prog_len  <= '0;
      drop_cnt  <= '0;
      inst_vld  <= 1'b0;
      inst_last <= 1'b0;
      inst_id   <= '0;
      word      <= '0;
    end else begin
      if (prog_wr && prog_wr_last) begin
        prog_len <= {1'b0, prog_wr_addr} + LEN_W'(1);
      end
      case (state)
        ST_IDLE, ST_RESP: begin
          if (evaluate) begin
            state    <= ST_IDLE;
            inst_vld <= 1'b0;
            if (fifo_pop) begin
              if (head_hit) begin
                inst_id   <= head_id;
                word      <= store[head_pc];
                inst_last <= (({1'b0, head_pc} + LEN_W'(1)) == prog_len);
                cnt       <= CNT_W'(LATENCY - 1);
                if (LATENCY == 1) begin
                  state    <= ST_RESP;
                  inst_vld <= 1'b1;
                end else begin
                  state <= ST_WAIT;
                end
              end else if (drop_cnt != {PC_BIT{1'b1}}) begin
                drop_cnt <= drop_cnt + PC_BIT'(1);
              end
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= ST_RESP;
            inst_vld <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          inst_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb/tb_inst_fetch_responder.sv - self-checking bench for inst_fetch_responder
`timescale 1ns/1ps
module tb_inst_fetch_responder;

  localparam int PC_BIT  = 8;
  localparam int ID_BIT  = 8;
  localparam int OP_BIT  = 3;
  localparam int REG_BIT = 3;
  localparam int IMM_BIT = 4;
  localparam int INST_W  = 16;
  localparam int LAT     = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fetch_vld = 1'b0;
  logic               fetch_rdy;
  logic [ID_BIT-1:0]  fetch_id = '0;
  logic [PC_BIT-1:0]  fetch_pc = '0;
  logic               inst_vld;
  logic               inst_rdy = 1'b0;
  logic               inst_last;
  logic [OP_BIT-1:0]  inst_op;
  logic [ID_BIT-1:0]  inst_id;
  logic [REG_BIT-1:0] inst_dst_reg;
  logic [REG_BIT-1:0] inst_src_reg0;
  logic [REG_BIT-1:0] inst_src_reg1;
  logic [IMM_BIT-1:0] inst_imm;
  logic               prog_wr_vld = 1'b0;
  logic               prog_wr_rdy;
  logic [PC_BIT-1:0]  prog_wr_addr = '0;
  logic [INST_W-1:0]  prog_wr_data = '0;
  logic               prog_wr_last = 1'b0;
  logic [PC_BIT-1:0]  drop_cnt;
  logic               busy;

  always #5 clk = ~clk;

  inst_fetch_responder dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_vld     (fetch_vld),
    .fetch_rdy     (fetch_rdy),
    .fetch_id      (fetch_id),
    .fetch_pc      (fetch_pc),
    .inst_vld      (inst_vld),
    .inst_rdy      (inst_rdy),
    .inst_last     (inst_last),
    .inst_op       (inst_op),
    .inst_id       (inst_id),
    .inst_dst_reg  (inst_dst_reg),
    .inst_src_reg0 (inst_src_reg0),
    .inst_src_reg1 (inst_src_reg1),
    .inst_imm      (inst_imm),
    .prog_wr_vld   (prog_wr_vld),
    .prog_wr_rdy   (prog_wr_rdy),
    .prog_wr_addr  (prog_wr_addr),
    .prog_wr_data  (prog_wr_data),
    .prog_wr_last  (prog_wr_last),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  typedef struct {
    logic [7:0]  id;
    logic [15:0] word;
    logic        last;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem_m [256];
  int          plen_m = 0;
  int          drop_m = 0;
  resp_t       exp_q[$];
  int          req_pc[$];
  logic [7:0]  req_id[$];
  int          first_acc, first_hs, last_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] exp_fields(input resp_t e);
    int w;
    w = int'(e.word);
    return {e.id, 3'((w / 8192) % 8), 3'((w / 1024) % 8), 3'((w / 128) % 8),
            3'((w / 16) % 8), 4'(w % 16), e.last};
  endfunction

  function automatic logic [24:0] obs_fields();
    return {inst_id, inst_op, inst_dst_reg, inst_src_reg0, inst_src_reg1, inst_imm, inst_last};
  endfunction

  task automatic check_front(input string tag);
    if (exp_q.size() == 0) check({tag, "_unexpected_vld"}, 64'(inst_vld), 64'(0));
    else                   check(tag, 64'(obs_fields()), 64'(exp_fields(exp_q[0])));
  endtask

  task automatic model_accept(input int pc, input logic [7:0] id);
    resp_t e;
    if (pc < plen_m) begin
      e.id = id; e.word = mem_m[pc]; e.last = (pc == plen_m - 1);
      exp_q.push_back(e);
    end else if (drop_m < 255) begin
      drop_m++;
    end
  endtask

  task automatic load(input int addr, input logic [15:0] data, input bit last);
    int n;
    n = 0;
    prog_wr_vld = 1'b1; prog_wr_addr = 8'(addr); prog_wr_data = data; prog_wr_last = last;
    while (!prog_wr_rdy && n < 50) begin @(posedge clk); #1; n++; end
    check("load_wr_rdy", 64'(prog_wr_rdy), 64'(1));
    @(posedge clk); #1;
    prog_wr_vld = 1'b0; prog_wr_last = 1'b0;
    mem_m[addr] = data;
    if (last) plen_m = addr + 1;
  endtask

  task automatic push_req(input int pc, input logic [7:0] id);
    int n;
    n = 0;
    fetch_vld = 1'b1; fetch_pc = 8'(pc); fetch_id = id;
    while (!fetch_rdy && n < 50) begin @(posedge clk); #1; n++; end
    check("push_fetch_rdy", 64'(fetch_rdy), 64'(1));
    @(posedge clk); #1;
    fetch_vld = 1'b0;
    model_accept(pc, id);
  endtask

  // Streams req_pc/req_id into the DUT and checks every visible response until drained.
  task automatic run(input int rdy_mode, input int max_cyc, input string tag);
    int cyc;
    bit done, acc, hs;
    cyc = 0; done = 0;
    first_acc = -1; first_hs = -1; last_hs = -1;
    while (!done && cyc < max_cyc) begin
      fetch_vld = (req_pc.size() > 0);
      if (fetch_vld) begin fetch_pc = 8'(req_pc[0]); fetch_id = req_id[0]; end
      inst_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
      acc = fetch_vld && fetch_rdy;
      if (inst_vld) check_front(tag);
      hs = inst_vld && inst_rdy;
      if (acc && first_acc < 0) first_acc = cyc;
      if (hs && first_hs < 0) first_hs = cyc;
      if (hs) last_hs = cyc;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        model_accept(req_pc[0], req_id[0]);
        void'(req_pc.pop_front()); void'(req_id.pop_front());
      end
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      done = (req_pc.size() == 0) && (exp_q.size() == 0) && !busy && !inst_vld;
    end
    fetch_vld = 1'b0;
    check({tag, "_drained"}, 64'(done), 64'(1));
  endtask

  initial begin
    int n_acc;
    logic [15:0] w, w_new;
    int plen;

    // Reset values
    @(posedge clk); #1;
    check("rst_fetch_rdy_low", 64'(fetch_rdy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_flags", 64'({fetch_rdy, inst_vld, prog_wr_rdy, busy}), 64'(4'b1010));
    check("rst_fields", 64'(obs_fields()), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));

    // 4-word program, in-order responses, latency and throughput
    for (int i = 0; i < 4; i++) load(i, 16'($urandom), i == 3);
    for (int i = 0; i < 4; i++) begin req_pc.push_back(i); req_id.push_back(8'(10 + i)); end
    run(0, 200, "t1_resp");
    check("t1_latency", 64'(first_hs - first_acc), 64'(1 + LAT));
    check("t1_throughput", 64'(last_hs - first_hs), 64'(3 * LAT));
    check("t1_drop_cnt", 64'(drop_cnt), 64'(drop_m));

    // Exact field decode of a single-word program
    w = 16'(5 * 8192 + 2 * 1024 + 3 * 128 + 4 * 16 + 9);
    load(0, w, 1);
    req_pc.push_back(0); req_id.push_back(8'($urandom));
    run(0, 100, "t2_decode");

    // Back-pressure: FIFO fills behind a held response
    inst_rdy = 1'b0; n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      fetch_vld = 1'b1; fetch_pc = 8'd0; fetch_id = 8'($urandom);
      if (inst_vld) check_front("t3_hold");
      if (fetch_rdy) begin
        @(posedge clk); #1;
        model_accept(0, fetch_id); n_acc++;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("t3_accepted", 64'(n_acc), 64'(1 + 4));
    check("t3_fetch_rdy_full", 64'(fetch_rdy), 64'(0));
    fetch_vld = 1'b0;
    run(0, 300, "t3_release");

    // Program write while busy is refused and the store keeps its old word
    for (int i = 0; i < 4; i++) load(i, 16'($urandom), i == 3);
    inst_rdy = 1'b0;
    push_req(2, 8'($urandom));
    w_new = ~mem_m[2];
    prog_wr_vld = 1'b1; prog_wr_addr = 8'd2; prog_wr_data = w_new; prog_wr_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t6_wr_rdy_busy", 64'(prog_wr_rdy), 64'(0));
      @(posedge clk); #1;
    end
    check("t6_vld", 64'(inst_vld), 64'(1));
    check_front("t6_old_word");
    inst_rdy = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    load(2, w_new, 0);
    req_pc.push_back(2); req_id.push_back(8'($urandom));
    run(0, 100, "t6_new_word");

    // Out-of-range drops
    load(0, 16'($urandom), 0);
    load(1, 16'($urandom), 1);
    for (int i = 0; i < 4; i++) begin req_pc.push_back(i); req_id.push_back(8'(20 + i)); end
    run(0, 200, "t4_resp");
    check("t4_drop_cnt", 64'(drop_cnt), 64'(drop_m));
    check("t4_busy", 64'(busy), 64'(0));

    // Randomised program, addresses and core back-pressure
    plen = int'($urandom_range(1, 16));
    for (int i = 0; i < plen; i++) load(i, 16'($urandom), i == plen - 1);
    for (int i = 0; i < 40; i++) begin
      req_pc.push_back(int'($urandom_range(0, plen + 3)));
      req_id.push_back(8'($urandom));
    end
    run(1, 3000, "rand_resp");
    check("rand_drop_cnt", 64'(drop_cnt), 64'(drop_m));

    // Reset in the middle of a response with requests queued
    inst_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push_req(0, 8'(30 + i));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_vld_before_rst", 64'(inst_vld), 64'(1));
    check_front("t5_resp_before_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_state", 64'({inst_vld, busy, fetch_rdy}), 64'(3'b000));
    check("t5_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    rst = 1'b0;
    #1;
    check("t5_fetch_rdy", 64'(fetch_rdy), 64'(1));
    exp_q.delete(); plen_m = 0; drop_m = 0;
    req_pc.push_back(0); req_id.push_back(8'd40);
    run(0, 100, "t5_after_rst");
    check("t5_drop_after_rst", 64'(drop_cnt), 64'(drop_m));

    // drop_cnt saturation
    for (int i = 0; i < 260; i++) begin
      req_pc.push_back(int'($urandom_range(0, 255)));
      req_id.push_back(8'($urandom));
    end
    run(0, 2000, "sat_run");
    check("sat_drop_cnt", 64'(drop_cnt), 64'(drop_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
